// File: rtl/eth_rx_frame_checker_pkg.sv
// Shared parameters for the RX frame checker: beat geometry (cmn_params) and
// MAC-level constants, error-flag layout and FSM state type (mac_params).
package cmn_params;
    localparam int unsigned N_SYMBOLS = 8;
    localparam int unsigned W_SYMBOL  = 8;
endpackage

package mac_params;
    localparam int unsigned ERR_PAYLOAD = 0;
    localparam int unsigned ERR_KEEP    = 1;
    localparam int unsigned ERR_LEN     = 2;
    localparam int unsigned ERR_TUSER   = 3;
    localparam int unsigned W_ERR       = 4;
    localparam int unsigned W_LEN       = 16;
    localparam int unsigned MIN_LEN_DEF = 60;
    localparam int unsigned MAX_LEN_DEF = 1514;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } rx_state_t;

    // Field order matches the ERR_* bit positions (MSB first).
    typedef struct packed {
        logic tuser;
        logic len;
        logic keep;
        logic payload;
    } frame_err_t;
endpackage

// File: rtl/eth_sat_counter.sv
// Saturating accumulator with synchronous clear; clear wins over increment.
module eth_sat_counter #(
    parameter int unsigned W_CNT = 32,
    parameter int unsigned W_INC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_en_i,
    input  logic [W_INC-1:0] inc_i,
    output logic [W_CNT-1:0] cnt_o
);
    localparam int unsigned W_SUM = ((W_CNT > W_INC) ? W_CNT : W_INC) + 1;
    localparam logic [W_SUM-1:0] CNT_MAX = W_SUM'({W_CNT{1'b1}});

    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic [W_SUM-1:0] sum;

    always_comb begin
        sum   = W_SUM'(cnt_q) + W_SUM'(inc_i);
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_en_i) begin
            cnt_d = (sum > CNT_MAX) ? '1 : sum[W_CNT-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/eth_rx_frame_checker.sv
// Checks received frames against the incrementing-byte pattern, tkeep rules,
// length limits and tuser; keeps saturating good/bad/byte statistics.
module eth_rx_frame_checker
    import mac_params::*;
#(
    parameter int unsigned N_SYMBOLS = cmn_params::N_SYMBOLS,
    parameter int unsigned W_SYMBOL  = cmn_params::W_SYMBOL,
    parameter int unsigned MIN_LEN   = MIN_LEN_DEF,
    parameter int unsigned MAX_LEN   = MAX_LEN_DEF,
    parameter int unsigned W_CNT     = 32
) (
    input  logic                          i_rx_clk,
    input  logic                          i_rx_reset_n,
    input  logic                          m_axis_tvalid,
    input  logic [N_SYMBOLS*W_SYMBOL-1:0] m_axis_tdata,
    input  logic [N_SYMBOLS-1:0]          m_axis_tkeep,
    input  logic                          m_axis_tlast,
    input  logic                          m_axis_tuser,
    input  logic                          i_clear,
    output logic                          o_frame_done,
    output logic [W_ERR-1:0]              o_frame_err,
    output logic [W_LEN-1:0]              o_frame_len,
    output logic [W_CNT-1:0]              o_good_cnt,
    output logic [W_CNT-1:0]              o_bad_cnt,
    output logic [W_CNT-1:0]              o_byte_cnt
);
    localparam logic [N_SYMBOLS-1:0] KEEP_ALL = '1;

    rx_state_t           state_q, state_d;
    logic [W_SYMBOL-1:0] base_q, base_d;
    logic [W_LEN-1:0]    len_q, len_d;
    logic                pay_err_q, pay_err_d;
    logic                keep_err_q, keep_err_d;
    logic                done_q, done_d;
    frame_err_t          err_q, err_d;
    logic [W_LEN-1:0]    flen_q, flen_d;

    logic [W_SYMBOL-1:0]  seed;
    logic                 beat_pay_err;
    logic                 beat_keep_err;
    logic [W_LEN-1:0]     beat_cnt;
    logic [W_LEN:0]       len_sum;
    logic [W_LEN-1:0]     len_sat;
    logic [N_SYMBOLS-1:0] keep_p1;
    frame_err_t           fin_err;
    logic                 frame_end;
    logic                 good_en;
    logic                 bad_en;

    // Per-beat evaluation; in IDLE the beat itself supplies the seed and the length restarts.
    always_comb begin
        seed         = (state_q == IDLE) ? m_axis_tdata[W_SYMBOL-1:0] : base_q;
        beat_pay_err = 1'b0;
        beat_cnt     = '0;
        for (int j = 0; j < N_SYMBOLS; j++) begin
            if (m_axis_tkeep[j] &&
                (m_axis_tdata[j*W_SYMBOL +: W_SYMBOL] != (seed + W_SYMBOL'(j)))) begin
                beat_pay_err = 1'b1;
            end
            beat_cnt = beat_cnt + W_LEN'(m_axis_tkeep[j]);
        end
        keep_p1 = m_axis_tkeep + N_SYMBOLS'(1);
        if (m_axis_tlast) begin
            beat_keep_err = (m_axis_tkeep == '0) || ((m_axis_tkeep & keep_p1) != '0);
        end else begin
            beat_keep_err = (m_axis_tkeep != KEEP_ALL);
        end
        len_sum = ((state_q == IDLE) ? (W_LEN+1)'(0) : {1'b0, len_q}) + {1'b0, beat_cnt};
        len_sat = len_sum[W_LEN] ? '1 : len_sum[W_LEN-1:0];

        fin_err.payload = pay_err_q | beat_pay_err;
        fin_err.keep    = keep_err_q | beat_keep_err;
        fin_err.len     = (len_sat < W_LEN'(MIN_LEN)) || (len_sat > W_LEN'(MAX_LEN));
        fin_err.tuser   = m_axis_tuser;
    end

    // Next state, sticky flags and completion reporting.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        pay_err_d  = pay_err_q;
        keep_err_d = keep_err_q;
        done_d     = 1'b0;
        err_d      = err_q;
        flen_d     = flen_q;
        frame_end  = 1'b0;

        case (state_q)
            IDLE:     if (m_axis_tvalid && !m_axis_tlast) state_d = IN_FRAME;
            IN_FRAME: if (m_axis_tvalid && m_axis_tlast)  state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (m_axis_tvalid) begin
            if (m_axis_tlast) begin
                len_d      = '0;
                pay_err_d  = 1'b0;
                keep_err_d = 1'b0;
                done_d     = 1'b1;
                err_d      = fin_err;
                flen_d     = len_sat;
                frame_end  = 1'b1;
            end else begin
                base_d     = seed + W_SYMBOL'(N_SYMBOLS);
                len_d      = len_sat;
                pay_err_d  = fin_err.payload;
                keep_err_d = fin_err.keep;
            end
        end
    end

    assign good_en = frame_end && (fin_err == '0);
    assign bad_en  = frame_end && (fin_err != '0);

    always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
        if (!i_rx_reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            pay_err_q  <= 1'b0;
            keep_err_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            flen_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            pay_err_q  <= pay_err_d;
            keep_err_q <= keep_err_d;
            done_q     <= done_d;
            err_q      <= err_d;
            flen_q     <= flen_d;
        end
    end

    eth_sat_counter #(.W_CNT(W_CNT), .W_INC(1)) u_good_cnt (
        .clk      (i_rx_clk),
        .rst_n    (i_rx_reset_n),
        .clear_i  (i_clear),
        .inc_en_i (good_en),
        .inc_i    (1'b1),
        .cnt_o    (o_good_cnt)
    );

    eth_sat_counter #(.W_CNT(W_CNT), .W_INC(1)) u_bad_cnt (
        .clk      (i_rx_clk),
        .rst_n    (i_rx_reset_n),
        .clear_i  (i_clear),
        .inc_en_i (bad_en),
        .inc_i    (1'b1),
        .cnt_o    (o_bad_cnt)
    );

    eth_sat_counter #(.W_CNT(W_CNT), .W_INC(W_LEN)) u_byte_cnt (
        .clk      (i_rx_clk),
        .rst_n    (i_rx_reset_n),
        .clear_i  (i_clear),
        .inc_en_i (frame_end),
        .inc_i    (len_sat),
        .cnt_o    (o_byte_cnt)
    );

    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;
    assign o_frame_len  = flen_q;
endmodule

// File: doc/eth_rx_frame_checker.md
# eth_rx_frame_checker

Receive-side frame checker that sits directly downstream of the MAC/PCS core's RX AXI-Stream master (`m_axis_*`). It checks every received frame against the team's incrementing-byte test pattern, tkeep rules, length limits and the MAC-reported error flag (`tuser`). It keeps saturating statistics counters for loopback benches and on-board self-test. The block has no `tready` because the MAC RX stream cannot be back-pressured, so the checker accepts every valid beat.

## Interface
Parameters:
- N_SYMBOLS, default 8: bytes per beat (taken from the shared package).
- W_SYMBOL, default 8: bits per byte.
- MIN_LEN, default 60: minimum legal frame length in bytes, excluding FCS.
- MAX_LEN, default 1514: maximum legal frame length in bytes.
- W_CNT, default 32: width of the statistics counters.

Ports:
- i_rx_clk  in  1  RX clock, the only clock of the block.
- i_rx_reset_n  in  1  reset, asynchronous, active-low.
- m_axis_tvalid  in  1  beat valid.
- m_axis_tdata  in  N_SYMBOLS×W_SYMBOL  beat data; byte 0 is first on the wire.
- m_axis_tkeep  in  N_SYMBOLS  byte enables.
- m_axis_tlast  in  1  last beat of the frame.
- m_axis_tuser  in  1  MAC frame error; sampled only on the tlast beat.
- i_clear  in  1  synchronous pulse that clears all counters.
- o_frame_done  out  1  one-cycle pulse after each completed frame.
- o_frame_err  out  4  error flags of the last completed frame: {tuser, len, keep, payload}.
- o_frame_len  out  16  byte length of the last completed frame, saturating.
- o_good_cnt  out  W_CNT  count of frames with no error flags set.
- o_bad_cnt  out  W_CNT  count of frames with any error flag set.
- o_byte_cnt  out  W_CNT  total bytes received, including bytes of bad frames.

## Operation
- FSM has two states.
  - IDLE: the next valid beat is the first beat of a frame.
  - IN_FRAME: a frame is in progress. tvalid=0 gaps are legal and hold all state.
- Pattern check on the first beat:
  - Seed S = tdata byte 0.
  - Expected byte j is S+j mod 256.
  - The running expected base for the next beat is S+N_SYMBOLS.
- Pattern check on later beats: expected byte j is base+j; base then advances by N_SYMBOLS, mod 256.
- Only bytes with tkeep=1 are compared. Any mismatch sets the sticky payload flag.
- Keep rule:
  - Non-last beats must have tkeep all ones.
  - The last beat must have a contiguous LSB-aligned mask that is not zero (0x01, 0x03 … 0xFF).
  - A violation sets the keep flag.
- Length:
  - The length accumulates popcount(tkeep) and saturates at 0xFFFF.
  - On tlast, the len flag is set if length < MIN_LEN or length > MAX_LEN.
- tuser flag is taken from m_axis_tuser on the tlast beat.
- A single-beat frame (first beat and tlast together) is checked as both first and last beat. The FSM stays in IDLE.
- Completion:
  - On the tlast beat, the next edge registers o_frame_done=1, o_frame_err and o_frame_len.
  - On the same edge, o_good_cnt or o_bad_cnt increments, and o_byte_cnt adds the frame length.
  - The FSM then returns to IDLE and the sticky flags clear.
- All counters saturate at all ones and never wrap.
- i_clear zeroes the three counters on the next edge and has priority over a simultaneous completion. In that case the completing frame is not counted, but o_frame_done, o_frame_err and o_frame_len are still reported.

## Timing
- All outputs are registered.
- Reset values: o_frame_done=0, o_frame_err=0, o_frame_len=0, all counters 0, FSM in IDLE, base 0, sticky flags clear.
- Latency is one cycle from the tlast beat to the o_frame_done pulse and to the counter update.
- Back-to-back frames are supported: a new first beat may arrive in the cycle immediately after tlast, while o_frame_done is high.
- Reset asserted mid-frame discards the partial frame and nothing is counted. After release, the next valid beat starts a new frame.
- Throughput is one beat per cycle with no stalls.

## Structure
- Shared package `mac_params` gets:
  - The error-flag bit positions: ERR_PAYLOAD=0, ERR_KEEP=1, ERR_LEN=2, ERR_TUSER=3.
  - The defaults for MIN_LEN and MAX_LEN.
  - The FSM state enum (IDLE, IN_FRAME).
- N_SYMBOLS and W_SYMBOL come from `cmn_params`.
- Natural sub-module: `eth_sat_counter`, a saturating accumulator with parameters width and increment width, plus a clear input. It is instantiated three times.

## Test plan
- 64-byte frame, seed 0x10, 8 full beats with the last tkeep=0xFF, tuser=0: o_frame_done is high one cycle after tlast, o_frame_err=0, o_frame_len=64, o_good_cnt=1, o_byte_cnt=64.
- 61-byte frame, seed 0xFC, last tkeep=0x1F: payload wraps 0xFF→0x00 with no error, o_frame_len=61, the frame counts as good.
- 64-byte frame with byte 20 corrupted, followed back-to-back by a clean frame: the first frame reports o_frame_err=0b0001, the second 0b0000, o_bad_cnt=1, o_good_cnt=1.
- Faults in separate frames:
  - Mid-frame tkeep=0x7F gives err=0b0010.
  - Last tkeep=0x05 gives err=0b0010.
  - A 40-byte frame gives err=0b0100.
  - A 1600-byte frame gives err=0b0100.
  - tuser=1 on tlast gives err=0b1000.
- tvalid gaps of 3 cycles between beats of a 64-byte frame give the same result as the gap-free case. Reset asserted mid-frame leaves counters at 0 and o_frame_done is not pulsed.
- i_clear on the same cycle as a completion gives counters 0 and o_frame_done=1. Forcing 2^W_CNT−1 good frames (with a small W_CNT) keeps o_good_cnt saturated at all ones.
